dmem_arbiter: RTL and testbench

- Shares the single data-memory port between two requesters: the CPU M stage (port C) and a DMA/loader engine (port D).
- Grants one transaction at a time and holds the winner's address, data and strobes registered toward memory until the memory acknowledges.
- Returns the response to the winner only, and drives the stall request the hazard unit ORs into the pipeline stall.
- Sits between the M-stage BE/DP logic and the external m_data bus.

---
 rtl/dmem_arbiter.sv | 173 +++++++++++++++++
 tb/tb_dmem_arbiter.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter
// Shares the single data-memory port between the CPU M stage (port C) and a
// DMA/loader engine (port D). One transaction is granted at a time. The
// winner's request is registered onto the mem_* outputs and held there until
// memory acknowledges or the watchdog fires. The response is returned to the
// winner only.
//
// Parameters
//   ROUND_ROBIN : 1 = alternate grants under contention, 0 = port C always wins
//   TIMEOUT     : BUSY cycles without mem_ready_i before a forced error end (0 = off)
//   CNT_W       : width of the watchdog counter, must hold TIMEOUT
//
// Ports
//   clk_i, reset_i              clock, synchronous active-high reset
//   c_req_i .. c_byteen_i       CPU request (held until c_done_o)
//   c_rdata_o/c_done_o/c_err_o  CPU response, combinational in the finishing cycle
//   stall_cpu_o                 c_req_i && !c_done_o, to the hazard unit
//   d_* (same as c_*)           DMA request / response
//   mem_en_o .. mem_byteen_o    registered memory request
//   mem_rdata_i, mem_ready_i    memory response / acknowledge
module dmem_arbiter #(
  parameter bit          ROUND_ROBIN = 1'b1,
  parameter int unsigned TIMEOUT     = 16,
  parameter int unsigned CNT_W       = 5
) (
  input  logic        clk_i,
  input  logic        reset_i,
  // CPU port
  input  logic        c_req_i,
  input  logic        c_we_i,
  input  logic [31:0] c_addr_i,
  input  logic [31:0] c_wdata_i,
  input  logic [3:0]  c_byteen_i,
  output logic [31:0] c_rdata_o,
  output logic        c_done_o,
  output logic        c_err_o,
  output logic        stall_cpu_o,
  // DMA port
  input  logic        d_req_i,
  input  logic        d_we_i,
  input  logic [31:0] d_addr_i,
  input  logic [31:0] d_wdata_i,
  input  logic [3:0]  d_byteen_i,
  output logic [31:0] d_rdata_o,
  output logic        d_done_o,
  output logic        d_err_o,
  // Memory port
  output logic        mem_en_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic [3:0]  mem_byteen_o,
  input  logic [31:0] mem_rdata_i,
  input  logic        mem_ready_i
);

  typedef enum logic {IDLE, BUSY} state_e;

  localparam logic OWN_C = 1'b0;
  localparam logic OWN_D = 1'b1;

  // Counter value seen in the last BUSY cycle before the watchdog fires.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_e           state_q;
  logic             owner_q;
  logic             last_grant_q;
  logic [CNT_W-1:0] cnt_q;
  logic             mem_en_q;
  logic             mem_we_q;
  logic [31:0]      mem_addr_q;
  logic [31:0]      mem_wdata_q;
  logic [3:0]       mem_byteen_q;

  logic             any_req;
  logic             grant_sel;
  logic             win_we;
  logic [31:0]      win_addr;
  logic [31:0]      win_wdata;
  logic [3:0]       win_byteen;
  logic             busy;
  logic             ack;
  logic             timeout_hit;
  logic             finish;

  // Arbitration: a lone requester wins; under contention round-robin picks
  // the port that did not win last time, fixed priority always picks C.
  always_comb begin
    any_req   = c_req_i | d_req_i;
    grant_sel = OWN_C;
    if (c_req_i && d_req_i) begin
      grant_sel = ROUND_ROBIN ? ~last_grant_q : OWN_C;
    end else if (d_req_i) begin
      grant_sel = OWN_D;
    end
    win_we     = (grant_sel == OWN_D) ? d_we_i     : c_we_i;
    win_addr   = (grant_sel == OWN_D) ? d_addr_i   : c_addr_i;
    win_wdata  = (grant_sel == OWN_D) ? d_wdata_i  : c_wdata_i;
    win_byteen = (grant_sel == OWN_D) ? d_byteen_i : c_byteen_i;
  end

  // Ending conditions. A reset cycle never reports done, so an aborted
  // transaction is silent. An acknowledge in the watchdog cycle wins.
  always_comb begin
    busy        = (state_q == BUSY);
    ack         = busy && mem_ready_i && !reset_i;
    timeout_hit = (TIMEOUT != 0) && busy && !mem_ready_i &&
                  (cnt_q == CNT_LAST) && !reset_i;
    finish      = ack || timeout_hit;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q      <= IDLE;
      owner_q      <= OWN_C;
      last_grant_q <= OWN_D;
      cnt_q        <= '0;
      mem_en_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_byteen_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (any_req) begin
            owner_q      <= grant_sel;
            mem_en_q     <= 1'b1;
            mem_we_q     <= win_we;
            mem_addr_q   <= win_addr & 32'hFFFF_FFFC;
            mem_wdata_q  <= win_wdata;
            mem_byteen_q <= win_we ? win_byteen : 4'b0000;
            cnt_q        <= '0;
            state_q      <= BUSY;
          end
        end
        BUSY: begin
          if (finish) begin
            last_grant_q <= owner_q;
            mem_en_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_byteen_q <= '0;
            state_q      <= IDLE;
          end else begin
            // Only reached while mem_ready_i is low.
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Responses go to the owner only; a timed-out read returns zero data.
  always_comb begin
    c_done_o  = finish && (owner_q == OWN_C);
    c_err_o   = timeout_hit && (owner_q == OWN_C);
    c_rdata_o = (ack && (owner_q == OWN_C)) ? mem_rdata_i : 32'h0;
    d_done_o  = finish && (owner_q == OWN_D);
    d_err_o   = timeout_hit && (owner_q == OWN_D);
    d_rdata_o = (ack && (owner_q == OWN_D)) ? mem_rdata_i : 32'h0;
    stall_cpu_o = c_req_i && !c_done_o;
  end

  assign mem_en_o     = mem_en_q;
  assign mem_we_o     = mem_we_q;
  assign mem_addr_o   = mem_addr_q;
  assign mem_wdata_o  = mem_wdata_q;
  assign mem_byteen_o = mem_byteen_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter
// Directed bench for dmem_arbiter. Three instances share one set of inputs:
//   index 0 : ROUND_ROBIN=1, TIMEOUT=16
//   index 1 : ROUND_ROBIN=0, TIMEOUT=16
//   index 2 : ROUND_ROBIN=1, TIMEOUT=4
// Inputs change just after a rising edge and outputs are sampled on the
// falling edge, so the combinational done/err/rdata of the current cycle is seen.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        cReq, cWe, dReq, dWe, memReady;
  logic [31:0] cAddr, cWdata, dAddr, dWdata, memRdata;
  logic [3:0]  cByteen, dByteen;

  logic [31:0] cRdata [3];
  logic        cDone  [3];
  logic        cErr   [3];
  logic        stallCpu [3];
  logic [31:0] dRdata [3];
  logic        dDone  [3];
  logic        dErr   [3];
  logic        memEn  [3];
  logic        memWe  [3];
  logic [31:0] memAddr [3];
  logic [31:0] memWdata [3];
  logic [3:0]  memByteen [3];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.ROUND_ROBIN(1'b1), .TIMEOUT(16), .CNT_W(5)) u_rr (
    .clk_i(clk), .reset_i(reset),
    .c_req_i(cReq), .c_we_i(cWe), .c_addr_i(cAddr), .c_wdata_i(cWdata), .c_byteen_i(cByteen),
    .c_rdata_o(cRdata[0]), .c_done_o(cDone[0]), .c_err_o(cErr[0]), .stall_cpu_o(stallCpu[0]),
    .d_req_i(dReq), .d_we_i(dWe), .d_addr_i(dAddr), .d_wdata_i(dWdata), .d_byteen_i(dByteen),
    .d_rdata_o(dRdata[0]), .d_done_o(dDone[0]), .d_err_o(dErr[0]),
    .mem_en_o(memEn[0]), .mem_we_o(memWe[0]), .mem_addr_o(memAddr[0]),
    .mem_wdata_o(memWdata[0]), .mem_byteen_o(memByteen[0]),
    .mem_rdata_i(memRdata), .mem_ready_i(memReady)
  );

  dmem_arbiter #(.ROUND_ROBIN(1'b0), .TIMEOUT(16), .CNT_W(5)) u_fp (
    .clk_i(clk), .reset_i(reset),
    .c_req_i(cReq), .c_we_i(cWe), .c_addr_i(cAddr), .c_wdata_i(cWdata), .c_byteen_i(cByteen),
    .c_rdata_o(cRdata[1]), .c_done_o(cDone[1]), .c_err_o(cErr[1]), .stall_cpu_o(stallCpu[1]),
    .d_req_i(dReq), .d_we_i(dWe), .d_addr_i(dAddr), .d_wdata_i(dWdata), .d_byteen_i(dByteen),
    .d_rdata_o(dRdata[1]), .d_done_o(dDone[1]), .d_err_o(dErr[1]),
    .mem_en_o(memEn[1]), .mem_we_o(memWe[1]), .mem_addr_o(memAddr[1]),
    .mem_wdata_o(memWdata[1]), .mem_byteen_o(memByteen[1]),
    .mem_rdata_i(memRdata), .mem_ready_i(memReady)
  );

  dmem_arbiter #(.ROUND_ROBIN(1'b1), .TIMEOUT(4), .CNT_W(5)) u_to (
    .clk_i(clk), .reset_i(reset),
    .c_req_i(cReq), .c_we_i(cWe), .c_addr_i(cAddr), .c_wdata_i(cWdata), .c_byteen_i(cByteen),
    .c_rdata_o(cRdata[2]), .c_done_o(cDone[2]), .c_err_o(cErr[2]), .stall_cpu_o(stallCpu[2]),
    .d_req_i(dReq), .d_we_i(dWe), .d_addr_i(dAddr), .d_wdata_i(dWdata), .d_byteen_i(dByteen),
    .d_rdata_o(dRdata[2]), .d_done_o(dDone[2]), .d_err_o(dErr[2]),
    .mem_en_o(memEn[2]), .mem_we_o(memWe[2]), .mem_addr_o(memAddr[2]),
    .mem_wdata_o(memWdata[2]), .mem_byteen_o(memByteen[2]),
    .mem_rdata_i(memRdata), .mem_ready_i(memReady)
  );

  // Advance to just after the next rising edge.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Drive request/memory handshake inputs for this cycle, then wait for the
  // sampling point on the falling edge.
  task automatic applyStimulus(input logic cr, input logic dr,
                               input logic mr, input logic [31:0] mrd);
    cReq     = cr;
    dReq     = dr;
    memReady = mr;
    memRdata = mrd;
    @(negedge clk);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic doReset;
    reset    = 1'b1;
    cReq     = 1'b0;
    dReq     = 1'b0;
    memReady = 1'b0;
    memRdata = 32'h0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    cWe = 0; cAddr = 0; cWdata = 0; cByteen = 0;
    dWe = 0; dAddr = 0; dWdata = 0; dByteen = 0;

    // Reset state of every instance
    doReset();
    applyStimulus(0, 0, 0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      checkOutput("rst_mem_en", memEn[i], 0);
      checkOutput("rst_mem_we", memWe[i], 0);
      checkOutput("rst_mem_addr", memAddr[i], 0);
      checkOutput("rst_mem_wdata", memWdata[i], 0);
      checkOutput("rst_mem_byteen", memByteen[i], 0);
      checkOutput("rst_c_done", cDone[i], 0);
      checkOutput("rst_d_done", dDone[i], 0);
    end
    tick();

    // CPU read alone, zero-wait memory
    $display("[TB] CPU read alone");
    cWe = 0; cAddr = 32'h0000_1006; cWdata = 32'hDEAD_BEEF; cByteen = 4'hF;
    applyStimulus(1, 0, 1, 32'hCAFE_0001);
    checkOutput("rd_c0_stall", stallCpu[0], 1);
    checkOutput("rd_c0_mem_en", memEn[0], 0);
    checkOutput("rd_c0_c_done", cDone[0], 0);
    tick();
    applyStimulus(1, 0, 1, 32'hCAFE_0001);
    checkOutput("rd_c1_mem_en", memEn[0], 1);
    checkOutput("rd_c1_mem_addr", memAddr[0], 32'h0000_1004);
    checkOutput("rd_c1_mem_byteen", memByteen[0], 0);
    checkOutput("rd_c1_mem_we", memWe[0], 0);
    checkOutput("rd_c1_c_done", cDone[0], 1);
    checkOutput("rd_c1_c_rdata", cRdata[0], 32'hCAFE_0001);
    checkOutput("rd_c1_c_err", cErr[0], 0);
    checkOutput("rd_c1_stall", stallCpu[0], 0);
    checkOutput("rd_c1_d_done", dDone[0], 0);
    checkOutput("rd_c1_d_rdata", dRdata[0], 0);
    tick();
    applyStimulus(0, 0, 1, 32'hCAFE_0001);
    checkOutput("rd_c2_mem_en", memEn[0], 0);
    checkOutput("rd_c2_c_done", cDone[0], 0);
    tick();

    // Contention with writes: round-robin (0) and fixed priority (1)
    $display("[TB] Write contention");
    doReset();
    cWe = 1; cAddr = 32'h0000_2000; cWdata = 32'h1111_1111; cByteen = 4'b0011;
    dWe = 1; dAddr = 32'h0000_3008; dWdata = 32'h2222_2222; dByteen = 4'b1100;
    applyStimulus(1, 1, 1, 32'h0BAD_F00D);
    checkOutput("ct_c0_stall", stallCpu[0], 1);
    checkOutput("ct_c0_mem_en", memEn[0], 0);
    tick();
    applyStimulus(1, 1, 1, 32'h0BAD_F00D);
    checkOutput("ct_c1_rr_addr", memAddr[0], 32'h0000_2000);
    checkOutput("ct_c1_rr_byteen", memByteen[0], 4'b0011);
    checkOutput("ct_c1_rr_wdata", memWdata[0], 32'h1111_1111);
    checkOutput("ct_c1_rr_we", memWe[0], 1);
    checkOutput("ct_c1_rr_c_done", cDone[0], 1);
    checkOutput("ct_c1_rr_d_done", dDone[0], 0);
    checkOutput("ct_c1_fp_c_done", cDone[1], 1);
    checkOutput("ct_c1_fp_d_done", dDone[1], 0);
    tick();
    applyStimulus(1, 1, 1, 32'h0BAD_F00D);
    checkOutput("ct_c2_rr_mem_en", memEn[0], 0);
    checkOutput("ct_c2_rr_c_done", cDone[0], 0);
    checkOutput("ct_c2_rr_d_done", dDone[0], 0);
    checkOutput("ct_c2_fp_mem_en", memEn[1], 0);
    tick();
    applyStimulus(1, 1, 1, 32'h0BAD_F00D);
    checkOutput("ct_c3_rr_addr", memAddr[0], 32'h0000_3008);
    checkOutput("ct_c3_rr_byteen", memByteen[0], 4'b1100);
    checkOutput("ct_c3_rr_wdata", memWdata[0], 32'h2222_2222);
    checkOutput("ct_c3_rr_d_done", dDone[0], 1);
    checkOutput("ct_c3_rr_d_rdata", dRdata[0], 32'h0BAD_F00D);
    checkOutput("ct_c3_rr_c_done", cDone[0], 0);
    checkOutput("ct_c3_rr_c_rdata", cRdata[0], 0);
    checkOutput("ct_c3_fp_addr", memAddr[1], 32'h0000_2000);
    checkOutput("ct_c3_fp_c_done", cDone[1], 1);
    checkOutput("ct_c3_fp_d_done", dDone[1], 0);
    tick();
    applyStimulus(1, 1, 1, 32'h0BAD_F00D);
    checkOutput("ct_c4_rr_mem_en", memEn[0], 0);
    tick();
    applyStimulus(1, 1, 1, 32'h0BAD_F00D);
    checkOutput("ct_c5_rr_addr", memAddr[0], 32'h0000_2000);
    checkOutput("ct_c5_rr_c_done", cDone[0], 1);
    checkOutput("ct_c5_rr_d_done", dDone[0], 0);
    checkOutput("ct_c5_fp_c_done", cDone[1], 1);
    checkOutput("ct_c5_fp_d_done", dDone[1], 0);
    tick();
    applyStimulus(0, 1, 1, 32'h0BAD_F00D);
    checkOutput("ct_c6_fp_mem_en", memEn[1], 0);
    checkOutput("ct_c6_fp_stall", stallCpu[1], 0);
    tick();
    applyStimulus(0, 1, 1, 32'h0BAD_F00D);
    checkOutput("ct_c7_fp_addr", memAddr[1], 32'h0000_3008);
    checkOutput("ct_c7_fp_d_done", dDone[1], 1);
    checkOutput("ct_c7_fp_c_done", cDone[1], 0);
    checkOutput("ct_c7_rr_d_done", dDone[0], 1);
    tick();
    applyStimulus(0, 0, 0, 32'h0);
    tick();

    // DMA read with a 3-cycle memory delay
    $display("[TB] DMA read, delayed acknowledge");
    doReset();
    dWe = 0; dAddr = 32'h0000_4003; dWdata = 32'h5555_5555; dByteen = 4'hF;
    applyStimulus(0, 1, 0, 32'h0);
    tick();
    for (int i = 1; i <= 3; i++) begin
      applyStimulus(0, 1, 0, 32'h0);
      checkOutput("dly_mem_en", memEn[0], 1);
      checkOutput("dly_mem_addr", memAddr[0], 32'h0000_4000);
      checkOutput("dly_mem_byteen", memByteen[0], 0);
      checkOutput("dly_mem_we", memWe[0], 0);
      checkOutput("dly_d_done", dDone[0], 0);
      checkOutput("dly_c_done", cDone[0], 0);
      tick();
    end
    applyStimulus(0, 1, 1, 32'hA5A5_0F0F);
    checkOutput("dly_ack_mem_addr", memAddr[0], 32'h0000_4000);
    checkOutput("dly_ack_d_done", dDone[0], 1);
    checkOutput("dly_ack_d_err", dErr[0], 0);
    checkOutput("dly_ack_d_rdata", dRdata[0], 32'hA5A5_0F0F);
    checkOutput("dly_ack_c_done", cDone[0], 0);
    checkOutput("dly_ack_c_err", cErr[0], 0);
    checkOutput("dly_ack_c_rdata", cRdata[0], 0);
    checkOutput("dly_ack_to4_d_done", dDone[2], 1);
    checkOutput("dly_ack_to4_d_err", dErr[2], 0);
    tick();
    applyStimulus(0, 0, 0, 32'h0);
    checkOutput("dly_idle_mem_en", memEn[0], 0);
    checkOutput("dly_idle_d_done", dDone[0], 0);
    tick();

    // CPU read that never gets an acknowledge: watchdog with TIMEOUT=4
    $display("[TB] Watchdog");
    doReset();
    cWe = 0; cAddr = 32'h0000_5000;
    applyStimulus(1, 0, 0, 32'hFFFF_FFFF);
    tick();
    for (int i = 1; i <= 3; i++) begin
      applyStimulus(1, 0, 0, 32'hFFFF_FFFF);
      checkOutput("to_wait_mem_en", memEn[2], 1);
      checkOutput("to_wait_c_done", cDone[2], 0);
      checkOutput("to_wait_stall", stallCpu[2], 1);
      tick();
    end
    applyStimulus(1, 0, 0, 32'hFFFF_FFFF);
    checkOutput("to_c_done", cDone[2], 1);
    checkOutput("to_c_err", cErr[2], 1);
    checkOutput("to_c_rdata", cRdata[2], 0);
    checkOutput("to_stall", stallCpu[2], 0);
    checkOutput("to_d_err", dErr[2], 0);
    checkOutput("to_long_c_done", cDone[0], 0);
    tick();
    applyStimulus(0, 0, 0, 32'hFFFF_FFFF);
    checkOutput("to_idle_mem_en", memEn[2], 0);
    checkOutput("to_idle_c_done", cDone[2], 0);
    tick();

    // Acknowledge in the watchdog cycle counts as a normal completion
    doReset();
    applyStimulus(1, 0, 0, 32'h0);
    tick();
    for (int i = 1; i <= 3; i++) begin
      applyStimulus(1, 0, 0, 32'h0);
      checkOutput("toack_wait_c_done", cDone[2], 0);
      tick();
    end
    applyStimulus(1, 0, 1, 32'h1234_5678);
    checkOutput("toack_c_done", cDone[2], 1);
    checkOutput("toack_c_err", cErr[2], 0);
    checkOutput("toack_c_rdata", cRdata[2], 32'h1234_5678);
    tick();
    applyStimulus(0, 0, 0, 32'h0);
    checkOutput("toack_idle_mem_en", memEn[2], 0);
    tick();

    // Reset during a BUSY write, then contention must favour C again
    $display("[TB] Reset while busy");
    doReset();
    cWe = 1; cAddr = 32'h0000_6000; cWdata = 32'h6666_6666; cByteen = 4'b1010;
    dWe = 1; dAddr = 32'h0000_7000; dWdata = 32'h7777_7777; dByteen = 4'b0101;
    applyStimulus(1, 0, 1, 32'h0);
    tick();
    applyStimulus(1, 0, 1, 32'h0);
    checkOutput("rb_first_c_done", cDone[0], 1);
    tick();
    cAddr = 32'h0000_6100;
    applyStimulus(1, 0, 0, 32'h0);
    checkOutput("rb_gap_mem_en", memEn[0], 0);
    tick();
    applyStimulus(1, 0, 0, 32'h0);
    checkOutput("rb_busy_mem_en", memEn[0], 1);
    checkOutput("rb_busy_mem_addr", memAddr[0], 32'h0000_6100);
    checkOutput("rb_busy_mem_byteen", memByteen[0], 4'b1010);
    tick();
    reset = 1'b1;
    applyStimulus(1, 0, 0, 32'h0);
    checkOutput("rb_rst_c_done", cDone[0], 0);
    checkOutput("rb_rst_c_err", cErr[0], 0);
    checkOutput("rb_rst_stall", stallCpu[0], 1);
    tick();
    reset = 1'b0;
    applyStimulus(1, 1, 1, 32'h0);
    checkOutput("rb_after_mem_en", memEn[0], 0);
    checkOutput("rb_after_c_done", cDone[0], 0);
    tick();
    applyStimulus(1, 1, 1, 32'h0);
    checkOutput("rb_grant_mem_addr", memAddr[0], 32'h0000_6100);
    checkOutput("rb_grant_mem_byteen", memByteen[0], 4'b1010);
    checkOutput("rb_grant_c_done", cDone[0], 1);
    checkOutput("rb_grant_d_done", dDone[0], 0);
    tick();
    applyStimulus(0, 0, 0, 32'h0);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
